// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the instruction-memory boot loader:
//   - state_t        : loader controller states (LOAD, HOLD, RUN, ERR)
//   - BYTE_W         : width of one memory byte
//   - WORD_BYTES_DEF : default number of bytes per fetched instruction word
//   - be_lane_lsb()  : bit position of read lane i inside a big-endian word
// ---------------------------------------------------------------------------
package loader_pkg;

   localparam int BYTE_W         = 8;
   localparam int WORD_BYTES_DEF = 4;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_HOLD = 2'd1,
      ST_RUN  = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   // Lane 0 is the byte at the fetch address and lands in the most
   // significant byte of the word; the last lane lands in the least
   // significant byte.
   function automatic int be_lane_lsb(input int lane, input int nbytes);
      return (nbytes - 1 - lane) * BYTE_W;
   endfunction

endpackage

// File: rtl/imem_byte_ram.sv
// ---------------------------------------------------------------------------
// imem_byte_ram
// DEPTH x 8 byte RAM with one synchronous write port and WORD_BYTES
// combinational read lanes. Lane i returns Mem[(raddr + i) mod DEPTH], so a
// word read may straddle the top of memory and wrap to address 0.
// Contents are never cleared; unwritten bytes read as X in simulation.
//
// Ports:
//   clk      in   write clock
//   we       in   write enable
//   waddr    in   write byte address
//   wdata    in   write byte
//   raddr    in   read base byte address
//   rd_lanes out  WORD_BYTES read bytes, lane 0 at raddr
// ---------------------------------------------------------------------------
module imem_byte_ram
   import loader_pkg::*;
#(
   parameter int DEPTH      = 512,
   parameter int ADDR_W     = 9,
   parameter int WORD_BYTES = WORD_BYTES_DEF
)(
   input  logic                                 clk,
   input  logic                                 we,
   input  logic [ADDR_W-1:0]                    waddr,
   input  logic [BYTE_W-1:0]                    wdata,
   input  logic [ADDR_W-1:0]                    raddr,
   output logic [WORD_BYTES-1:0][BYTE_W-1:0]    rd_lanes
);

   logic [BYTE_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // ADDR_W-bit addition wraps naturally because DEPTH == 2**ADDR_W.
   for (genvar i = 0; i < WORD_BYTES; i++) begin : g_lane
      logic [ADDR_W-1:0] lane_addr;
      assign lane_addr   = raddr + ADDR_W'(i);
      assign rd_lanes[i] = mem[lane_addr];
   end

endmodule

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
// Program loader and instruction memory for the MIPS core. A byte stream
// arriving over a valid/ready handshake is written into a DEPTH-byte RAM
// while the core is held in reset. Once the image ends (in_last, or the
// memory fills up) the core stays in reset for RESET_HOLD more cycles and is
// then released. Instruction words are served big-endian to the fetch stage
// at any time. A restart pulse in RUN re-enters the load phase.
//
// Optional feature: define LOADER_CHECKSUM_EN to keep an 8-bit running sum
// of the accepted bytes; a non-zero final sum parks the loader in ERR with
// checksum_err set. Without the macro checksum_err is tied low.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   in_valid     in   input byte valid
//   in_data      in   program byte
//   in_last      in   final byte of the image
//   in_ready     out  loader accepts a byte this cycle (LOAD only)
//   restart      in   pulse; re-enters LOAD from RUN (or ERR)
//   fetch_addr   in   byte address of the instruction fetch
//   fetch_data   out  big-endian word at fetch_addr (combinational)
//   cpu_reset    out  reset to the MIPS core
//   load_done    out  high in RUN
//   load_count   out  bytes written in the current or last load
//   overflow     out  sticky; memory filled without in_last
//   checksum_err out  final byte sum non-zero (LOADER_CHECKSUM_EN only)
// ---------------------------------------------------------------------------
module imem_boot_loader
   import loader_pkg::*;
#(
   parameter int DEPTH      = 512,
   parameter int ADDR_W     = 9,
   parameter int WORD_BYTES = WORD_BYTES_DEF,
   parameter int RESET_HOLD = 2
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   input  logic [BYTE_W-1:0]             in_data,
   input  logic                          in_last,
   output logic                          in_ready,
   input  logic                          restart,
   input  logic [ADDR_W-1:0]             fetch_addr,
   output logic [BYTE_W*WORD_BYTES-1:0]  fetch_data,
   output logic                          cpu_reset,
   output logic                          load_done,
   output logic [ADDR_W:0]               load_count,
   output logic                          overflow,
   output logic                          checksum_err
);

   localparam int                HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t                            state;
   logic [ADDR_W-1:0]                 ptr;
   logic [HOLD_W-1:0]                 hold_cnt;
   logic                              accept;
   logic                              at_top;
   logic                              load_end;
   logic                              sum_bad;
   logic                              do_restart;
   logic [WORD_BYTES-1:0][BYTE_W-1:0] rd_lanes;

   assign in_ready   = (state == ST_LOAD);
   assign accept     = in_valid & in_ready;
   assign at_top     = (ptr == LAST_ADDR);
   assign load_end   = accept & (in_last | at_top);
   // ERR shares the restart exit with RUN; the checksum logic needs the
   // same condition to clear its sum.
   assign do_restart = restart & ((state == ST_RUN) | (state == ST_ERR));

   imem_byte_ram #(
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W),
      .WORD_BYTES (WORD_BYTES)
   ) u_ram (
      .clk      (clk),
      .we       (accept),
      .waddr    (ptr),
      .wdata    (in_data),
      .raddr    (fetch_addr),
      .rd_lanes (rd_lanes)
   );

   always_comb begin
      fetch_data = '0;
      for (int i = 0; i < WORD_BYTES; i++) begin
         fetch_data[be_lane_lsb(i, WORD_BYTES) +: BYTE_W] = rd_lanes[i];
      end
   end

`ifdef LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0] sum;
   logic [BYTE_W-1:0] sum_next;

   // The final byte is included in the sum that decides the outcome.
   assign sum_next = sum + in_data;
   assign sum_bad  = (sum_next != '0);

   always_ff @(posedge clk) begin
      if (reset || do_restart) begin
         sum          <= '0;
         checksum_err <= 1'b0;
      end else if (accept) begin
         sum <= sum_next;
         if (load_end && sum_bad) begin
            checksum_err <= 1'b1;
         end
      end
   end
`else
   assign sum_bad      = 1'b0;
   assign checksum_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_LOAD;
         ptr        <= '0;
         hold_cnt   <= '0;
         load_count <= '0;
         overflow   <= 1'b0;
         cpu_reset  <= 1'b1;
         load_done  <= 1'b0;
      end else begin
         case (state)
            ST_LOAD: begin
               if (accept) begin
                  // The pointer parks on the last byte rather than wrapping.
                  if (!at_top) begin
                     ptr <= ptr + 1'b1;
                  end
                  load_count <= load_count + 1'b1;
                  if (at_top && !in_last) begin
                     overflow <= 1'b1;
                  end
                  if (load_end) begin
                     hold_cnt <= '0;
                     state    <= sum_bad ? ST_ERR : ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (hold_cnt == HOLD_LAST) begin
                  state     <= ST_RUN;
                  cpu_reset <= 1'b0;
                  load_done <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            ST_RUN, ST_ERR: begin
               if (do_restart) begin
                  state      <= ST_LOAD;
                  ptr        <= '0;
                  load_count <= '0;
                  overflow   <= 1'b0;
                  cpu_reset  <= 1'b1;
                  load_done  <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Synthesizable program loader and instruction memory for the MIPS core.
- Accepts a byte stream over a valid/ready handshake and writes it into a byte-addressed RAM of DEPTH bytes.
- Holds the processor in reset until the load completes, then releases it.
- Serves big-endian instruction words to the fetch stage.
- Replaces file-based memory preload with hardware behaviour.

Parameters:
- DEPTH, 512, memory size in bytes; power of two.
- ADDR_W, 9, byte address width; equals log2(DEPTH).
- WORD_BYTES, 4, bytes per fetched word.
- RESET_HOLD, 2, cycles cpu_reset stays high after load completes; must be at least 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input byte valid.
- in_data  in  8  program byte.
- in_last  in  1  marks the final byte of the image.
- in_ready  out  1  loader accepts a byte this cycle.
- restart  in  1  single-cycle pulse; re-enters load from RUN.
- fetch_addr  in  ADDR_W  byte address of the instruction fetch.
- fetch_data  out  8*WORD_BYTES  big-endian word at fetch_addr.
- cpu_reset  out  1  reset to the MIPS core.
- load_done  out  1  high in RUN.
- load_count  out  ADDR_W+1  bytes written in the current or last load.
- overflow  out  1  sticky; image filled DEPTH without in_last.
- checksum_err  out  1  see Optional Feature.

Behaviour:
- Reset is synchronous and active-high. On a clk edge with reset=1:
  - state=LOAD, ptr=0, load_count=0, overflow=0, checksum_err=0.
  - cpu_reset=1, load_done=0, in_ready=1.
  - RAM contents are not cleared.
- reset takes priority over every other input, including mid-load and in RUN.
- States are LOAD, HOLD, RUN, ERR. All outputs are registered except in_ready and fetch_data.
- LOAD:
  - in_ready=1.
  - On accept (in_valid & in_ready): Mem[ptr]<=in_data, ptr<=ptr+1, load_count<=load_count+1.
  - Accept with in_last=1 -> HOLD, hold counter=0.
  - Accept at ptr=DEPTH-1 with in_last=0 -> overflow<=1, go to HOLD. Pointer does not wrap; no further bytes are accepted.
  - in_valid=0 -> no change.
- HOLD:
  - in_ready=0, cpu_reset=1.
  - Counter increments each cycle.
  - When counter reaches RESET_HOLD-1 -> RUN.
  - Timing: in_last accepted at edge N gives cpu_reset=0 and load_done=1 after edge N+RESET_HOLD.
- RUN:
  - cpu_reset=0, load_done=1, in_ready=0.
  - Input bytes are ignored.
  - restart=1 -> LOAD: ptr=0, load_count=0, overflow=0, cpu_reset=1, load_done=0 on the next edge.
  - restart is ignored in LOAD and HOLD.
- fetch_data (combinational):
  - Byte i (i=0 most significant) = Mem[(fetch_addr+i) mod DEPTH].
  - Addresses wrap at DEPTH; no alignment check.
  - Valid in any state; returns current contents, including during LOAD.
  - Unwritten bytes are X in simulation.
- Simultaneous write and fetch to the same byte: fetch returns the old value until the edge.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- With the macro defined:
  - An 8-bit running sum (mod 256) is kept over all accepted bytes, including the last.
  - The sum is reset to 0 on reset and on restart.
  - When the load ends (in_last or overflow), a non-zero final sum sets checksum_err<=1 and goes to ERR instead of HOLD.
  - ERR: cpu_reset=1, in_ready=0, load_done=0. Exit only via reset or restart.
- Without the macro: checksum_err is tied 0 and the ERR state is unreachable/absent.

Decomposition:
- Package loader_pkg holds:
  - the state enum (LOAD, HOLD, RUN, ERR);
  - BYTE_W=8;
  - the default WORD_BYTES;
  - a function computing the big-endian word from byte indices.
- One sub-module, imem_byte_ram:
  - DEPTH x 8 storage;
  - single synchronous write port;
  - WORD_BYTES combinational wrap-around read lanes.
- The controller FSM stays in imem_boot_loader.

Test Plan:
- Basic load: reset, stream 8 bytes 0x20 0x08 0x00 0x05 0x01 0x09 0x50 0x20 (last on the 8th).
  - load_count=8.
  - cpu_reset falls exactly RESET_HOLD edges after the last accept.
  - fetch_addr=0 -> 0x20080005; fetch_addr=4 -> 0x01095020.
- Backpressure gaps: same image with in_valid low on random cycles -> identical memory and load_count=8. in_ready=0 throughout HOLD/RUN; bytes offered then are not written.
- Overflow and wrap: stream DEPTH bytes with no in_last.
  - overflow=1, load_count=512, then RUN.
  - fetch_addr=510 -> {Mem[510],Mem[511],Mem[0],Mem[1]}.
- Restart and mid-load reset:
  - restart in RUN -> cpu_reset=1 next edge; reload of 4 bytes gives load_count=4.
  - reset asserted after 3 bytes of a load -> ptr=0, load_count=0, cpu_reset stays 1.
- Checksum (LOADER_CHECKSUM_EN):
  - Bytes 0x01 0x02 0xFD -> RUN, checksum_err=0.
  - Bytes 0x01 0x02 0xFC -> ERR, checksum_err=1, cpu_reset held 1 until restart.
